// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the 6-bit ALU's command buffer
// (alu_cmd_fifo) and the ALU-side result capture stage.
//
//   ALU_DATA_W : operand width (ALU a/b/s)
//   ALU_OP_W   : mode-select width (ALU m)
//   alu_cmd_t  : one operand command {a, b, m}
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 6;
    localparam int ALU_OP_W   = 2;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_OP_W-1:0]   m;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_mem.sv
// ---------------------------------------------------------------------------
// alu_cmd_mem
// DEPTH-entry storage array of alu_cmd_t words. Synchronous write,
// asynchronous read. Contents are not reset.
//
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : command to store
//   raddr : read address
//   rdata : command at raddr (combinational)
// ---------------------------------------------------------------------------
module alu_cmd_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  alu_cmd_t                 wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output alu_cmd_t                 rdata
);

    alu_cmd_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Command buffer in front of the 6-bit ALU. Accepts {a, b, m} commands over
// a valid/ready handshake, stores them in a DEPTH-entry FIFO, and presents
// the oldest command on registered outputs wired straight to the ALU.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : producer handshake (in_ready = not full)
//   in_a, in_b, in_m    : command from producer
//   out_valid/out_ready : consumer handshake (pop of the head command)
//   alu_a, alu_b, alu_m : registered head command, to ALU a/b/m
//   count               : occupancy 0..DEPTH (includes the head register)
//   ovf_sticky          : only with ALU_CMD_FIFO_OVF_FLAG_EN defined; set
//                         when in_valid is seen while full, cleared by reset
// ---------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [OP_W-1:0]          in_m,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_m,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_CMD_FIFO_OVF_FLAG_EN
    ,
    output logic                     ovf_sticky
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    alu_cmd_t      in_cmd;
    alu_cmd_t      next_cmd;

    // The head entry stays in memory too, so memory alone is full at
    // count == DEPTH and the entry after the head lives at rd_ptr + 1.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        in_cmd   = '0;
        in_cmd.a = in_a;
        in_cmd.b = in_b;
        in_cmd.m = in_m;
    end

    alu_cmd_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_cmd),
        .raddr (rd_ptr + AW'(1)),
        .rdata (next_cmd)
    );

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head register. A new command bypasses memory when it becomes the head
    // at once (FIFO empty, or the only entry is being popped). On a pop that
    // empties the FIFO only out_valid drops; the last values are held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_m     <= '0;
        end else if (pop && (count >= CW'(2))) begin
            out_valid <= 1'b1;
            alu_a     <= next_cmd.a;
            alu_b     <= next_cmd.b;
            alu_m     <= next_cmd.m;
        end else if (push && ((count == '0) || pop)) begin
            out_valid <= 1'b1;
            alu_a     <= in_a;
            alu_b     <= in_b;
            alu_m     <= in_m;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_CMD_FIFO_OVF_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule
